// File: rtl/seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// seq_pattern_tx
//
// Serial pattern transmitter. Accepts a parallel bit pattern over a
// valid/ready handshake and shifts it out MSB-first (bit len-1 first), one bit
// per clock, with optional contiguous or gapped repetitions. Drives the
// serial bit-stream interface consumed by the sequence-detector FSMs.
//
// Parameters:
//   WIDTH  maximum pattern length in bits (>= 2)
//   CNT_W  width of the repeat and gap counters
//
// Ports:
//   clk        in   clock
//   rst        in   synchronous, active-high reset
//   in_valid   in   pattern request valid
//   in_ready   out  block can accept a pattern (state is IDLE)
//   in_data    in   pattern bits, bit len-1 sent first
//   in_len     in   number of bits to send (clamped to WIDTH, 0 = none)
//   in_repeat  in   additional repetitions (0 = send once)
//   in_gap     in   idle cycles between repetitions
//   o          out  serial data bit (0 whenever o_valid is 0)
//   o_valid    out  o carries a pattern bit this cycle
//   busy       out  frame in progress (SEND or GAP)
//   done       out  one-cycle pulse, frame complete
// -----------------------------------------------------------------------------
module seq_pattern_tx #(
  parameter  int WIDTH = 8,
  parameter  int CNT_W = 4,
  localparam int LEN_W = $clog2(WIDTH) + 1,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [LEN_W-1:0] in_len,
  input  logic [CNT_W-1:0] in_repeat,
  input  logic [CNT_W-1:0] in_gap,
  output logic             o,
  output logic             o_valid,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_GAP  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_data;
  logic [IDX_W-1:0] r_first_idx;  // len-1, reloaded at the start of each repetition
  logic [IDX_W-1:0] r_idx;        // index of the bit currently on o
  logic [CNT_W-1:0] r_rep;        // repetitions still to send after the current one
  logic [CNT_W-1:0] r_gap;        // latched gap length
  logic [CNT_W-1:0] r_gap_cnt;    // gap cycles left, including the current one
  logic             r_o;
  logic             r_o_valid;
  logic             r_busy;
  logic             r_done;

  logic [LEN_W-1:0] w_len_eff;
  logic [IDX_W-1:0] w_first_idx;
  logic [IDX_W-1:0] w_idx_next;

  // Lengths beyond WIDTH are clamped so the index never leaves the pattern.
  assign w_len_eff   = (in_len > LEN_W'(WIDTH)) ? LEN_W'(WIDTH) : in_len;
  // Only meaningful when w_len_eff >= 1; the len=0 path never uses it.
  assign w_first_idx = IDX_W'(w_len_eff - LEN_W'(1));
  assign w_idx_next  = r_idx - IDX_W'(1);

  // NOTE: in_ready is a plain decode of the state register, not a registered
  // output, so a new accept can land on the same edge that ends the done cycle.
  assign in_ready = (r_state == S_IDLE);

  assign o       = r_o;
  assign o_valid = r_o_valid;
  assign busy    = r_busy;
  assign done    = r_done;

  // Outputs are computed one edge ahead: whatever is assigned to r_o/r_o_valid
  // here is what the consumer sees during the following cycle.
  // NOTE: every state element uses non-blocking assignment so all registers
  // update from the same pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_data      <= '0;
      r_first_idx <= '0;
      r_idx       <= '0;
      r_rep       <= '0;
      r_gap       <= '0;
      r_gap_cnt   <= '0;
      r_o         <= 1'b0;
      r_o_valid   <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_done <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_data      <= in_data;
            r_first_idx <= w_first_idx;
            r_rep       <= in_repeat;
            r_gap       <= in_gap;
            if (w_len_eff == '0) begin
              // Empty frame: nothing is sent, completion is reported at once.
              r_done <= 1'b1;
            end else begin
              r_state   <= S_SEND;
              r_idx     <= w_first_idx;
              r_o       <= in_data[w_first_idx];
              r_o_valid <= 1'b1;
              r_busy    <= 1'b1;
            end
          end
        end

        S_SEND: begin
          if (r_idx != '0) begin
            r_idx <= w_idx_next;
            r_o   <= r_data[w_idx_next];
          end else if (r_rep != '0) begin
            r_rep <= r_rep - CNT_W'(1);
            if (r_gap != '0) begin
              r_state   <= S_GAP;
              r_gap_cnt <= r_gap;
              r_o       <= 1'b0;
              r_o_valid <= 1'b0;
            end else begin
              // Zero gap: next repetition follows with no bubble.
              r_idx <= r_first_idx;
              r_o   <= r_data[r_first_idx];
            end
          end else begin
            r_state   <= S_IDLE;
            r_o       <= 1'b0;
            r_o_valid <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b1;
          end
        end

        S_GAP: begin
          if (r_gap_cnt == CNT_W'(1)) begin
            r_state   <= S_SEND;
            r_idx     <= r_first_idx;
            r_o       <= r_data[r_first_idx];
            r_o_valid <= 1'b1;
          end else begin
            r_gap_cnt <= r_gap_cnt - CNT_W'(1);
          end
        end

        default: begin
          r_state   <= S_IDLE;
          r_o       <= 1'b0;
          r_o_valid <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_pattern_tx.sv
// -----------------------------------------------------------------------------
// tb_seq_pattern_tx
//
// Directed bench for seq_pattern_tx (WIDTH=8, CNT_W=4). Inputs change 1 ns
// after each rising edge; outputs are sampled at the same point, i.e. they
// show the registered values for the cycle that just started.
// Expected per-cycle waveforms are written as bit vectors, leftmost bit first.
// -----------------------------------------------------------------------------
module tb_seq_pattern_tx;

  localparam int WIDTH = 8;
  localparam int CNT_W = 4;
  localparam int LEN_W = $clog2(WIDTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [LEN_W-1:0] in_len;
  logic [CNT_W-1:0] in_repeat;
  logic [CNT_W-1:0] in_gap;
  logic             o;
  logic             o_valid;
  logic             busy;
  logic             done;

  int n_vec = 0;
  int n_err = 0;

  seq_pattern_tx #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_len   (in_len),
    .in_repeat(in_repeat),
    .in_gap   (in_gap),
    .o        (o),
    .o_valid  (o_valid),
    .busy     (busy),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic observed, input logic expected);
    n_vec++;
    assert (observed === expected)
    else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, observed, expected);
    end
  endtask

  // Checks n consecutive cycles starting with the current one, advancing one
  // clock after each. Bit n-1 of each vector is the first cycle.
  task automatic stream(input string tag, input int n,
                        input logic [15:0] ev, input logic [15:0] eo,
                        input logic [15:0] eb, input logic [15:0] ed,
                        input logic [15:0] er);
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s c%0d o_valid", tag, i + 1), o_valid,  ev[4'(n - 1 - i)]);
      check($sformatf("%s c%0d o",       tag, i + 1), o,        eo[4'(n - 1 - i)]);
      check($sformatf("%s c%0d busy",    tag, i + 1), busy,     eb[4'(n - 1 - i)]);
      check($sformatf("%s c%0d done",    tag, i + 1), done,     ed[4'(n - 1 - i)]);
      check($sformatf("%s c%0d in_ready", tag, i + 1), in_ready, er[4'(n - 1 - i)]);
      tick();
    end
  endtask

  // Presents one request for a single edge; the caller is in cycle 1 of the
  // frame afterwards.
  task automatic send(input logic [7:0] d, input logic [3:0] l,
                      input logic [3:0] r, input logic [3:0] g);
    in_data   = d;
    in_len    = l;
    in_repeat = r;
    in_gap    = g;
    in_valid  = 1'b1;
    tick();
    in_valid  = 1'b0;
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b1;   // must be ignored while rst is high
    in_data   = 8'hFF;
    in_len    = 4'd8;
    in_repeat = 4'd0;
    in_gap    = 4'd0;

    // ---- Reset state ----
    tick();
    tick();
    check("reset o",        o,        1'b0);
    check("reset o_valid",  o_valid,  1'b0);
    check("reset busy",     busy,     1'b0);
    check("reset done",     done,     1'b0);
    check("reset in_ready", in_ready, 1'b1);
    in_valid = 1'b0;
    rst      = 1'b0;
    tick();
    check("post-reset in_ready", in_ready, 1'b1);
    check("post-reset o_valid",  o_valid,  1'b0);

    // ---- Single frame: 8'h0B len 4 -> 1,0,1,1 then done ----
    send(8'h0B, 4'd4, 4'd0, 4'd0);
    stream("single", 6,
           16'b111100, 16'b101100, 16'b111100, 16'b000010, 16'b000011);

    // ---- Repeat with gap: 8'h06 len 3 rep 1 gap 2 ----
    send(8'h06, 4'd3, 4'd1, 4'd2);
    stream("rep_gap", 10,
           16'b1110011100, 16'b1100011000, 16'b1111111100,
           16'b0000000010, 16'b0000000011);

    // ---- Zero length: done one cycle after accept, no bits ----
    send(8'hFF, 4'd0, 4'd3, 4'd1);
    stream("len0", 3,
           16'b000, 16'b000, 16'b000, 16'b100, 16'b111);

    // ---- Length clamp: in_len=12 sends all 8 bits of 8'hA5 ----
    send(8'hA5, 4'd12, 4'd0, 4'd0);
    stream("clamp", 10,
           16'b1111111100, 16'b1010010100, 16'b1111111100,
           16'b0000000010, 16'b0000000011);

    // ---- Reset mid-frame: 8'hC3 len 8, rst during the third bit ----
    send(8'hC3, 4'd8, 4'd0, 4'd0);
    stream("pre_abort", 2, 16'b11, 16'b11, 16'b11, 16'b00, 16'b00);
    check("abort bit2 o_valid", o_valid, 1'b1);
    check("abort bit2 o",       o,       1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    stream("abort", 3, 16'b000, 16'b000, 16'b000, 16'b000, 16'b111);

    // Frame after the abort: 8'h05 len 3 -> 1,0,1
    send(8'h05, 4'd3, 4'd0, 4'd0);
    stream("after_abort", 5,
           16'b11100, 16'b10100, 16'b11100, 16'b00010, 16'b00011);

    // ---- Back-to-back with contiguous repeat ----
    // Frame A: 8'h03 len 2 rep 2 gap 0 -> six contiguous 1s.
    in_data   = 8'h03;
    in_len    = 4'd2;
    in_repeat = 4'd2;
    in_gap    = 4'd0;
    in_valid  = 1'b1;
    tick();
    // Frame B queued behind it with in_valid held: 8'h02 len 2 -> 1,0.
    // Its fields differ from A's, so any early accept or leakage of the new
    // inputs into frame A shows up in the waveform.
    in_data   = 8'h02;
    in_len    = 4'd2;
    in_repeat = 4'd0;
    in_gap    = 4'd3;
    stream("b2b_A", 7,
           16'b1111110, 16'b1111110, 16'b1111110,
           16'b0000001, 16'b0000001);
    // B accepted at the edge closing A's done cycle; first bit now.
    in_valid = 1'b0;
    stream("b2b_B", 4,
           16'b1100, 16'b1000, 16'b1100, 16'b0010, 16'b0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
